// File: rtl/seg_pkg.sv
// seg_pkg
// Shared 7-segment display encoding used by both the display encoder and the
// scan readback decoder, so that encode and decode tables cannot diverge.
// Patterns are active-low: bit7 = dot, bits[6:0] = segments g..a.
// Table entries carry bit7 = 1 (dot off); the dot is handled separately.
package seg_pkg;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0,  // 0
        8'hF9,  // 1
        8'hA4,  // 2
        8'hB0,  // 3
        8'h99,  // 4
        8'h92,  // 5
        8'h82,  // 6
        8'hF8,  // 7
        8'h80,  // 8
        8'h90,  // 9
        8'h88,  // A
        8'h83,  // b
        8'hC6,  // C
        8'hA1,  // d
        8'h86,  // E
        8'h8E   // F
    };

    // All segments dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Encoder-side helper: hex value plus dot request to the active-low bus pattern.
    function automatic logic [7:0] seg_encode(input logic [3:0] hex, input logic dot);
        logic [7:0] pat;
        pat    = SEG_TABLE[hex];
        pat[7] = ~dot;
        return pat;
    endfunction

endpackage

// File: rtl/m_seg_to_hex.sv
// m_seg_to_hex
// Combinational inverse of the display encoding: maps a 7-bit active-low
// segment pattern back to its hex value by searching the shared table.
// Ports:
//   seg   in  7  active-low segments g..a
//   hit   out 1  pattern matches a hex digit
//   blank out 1  pattern is all segments dark
//   hex   out 4  decoded value (0 when no hit)
module m_seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] hex
);

    // Walk the table from the top down so the lowest matching index would win
    // if the table ever held a duplicate pattern.
    always_comb begin
        hit = 1'b0;
        hex = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (seg == SEG_TABLE[i][6:0]) begin
                hit = 1'b1;
                hex = 4'(i);
            end
        end
    end

    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/m_segment_scan_decoder.sv
// m_segment_scan_decoder
// Readback monitor for a multiplexed 7-segment display bus. Samples the
// segment bus and digit selects, waits for STABLE_CYCLES identical repeats,
// then inverse-decodes the pattern into the selected digit's slot.
// Ports:
//   clk         in   1       system clock
//   rst         in   1       synchronous reset, active-high
//   seg_in      in   8       active-low segments, [7]=dot, [6:0]=g..a
//   dig_sel     in   NDIG    active-low digit enables, expected one-hot-low
//   digits_out  out  4*NDIG  captured hex, digit i at [4i+3:4i]
//   dots_out    out  NDIG    dot lit on digit i
//   valid       out  NDIG    digit i holds a legal decoded value
//   upd         out  1       one-cycle pulse per capture attempt
//   err_pattern out  1       sticky: illegal segment pattern captured
//   err_sel     out  1       sticky: stable selection with >1 digit active
module m_segment_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] digits_out,
    output logic [NDIG-1:0]   dots_out,
    output logic [NDIG-1:0]   valid,
    output logic              upd,
    output logic              err_pattern,
    output logic              err_sel
);

    localparam int         SW      = NDIG + 8;
    localparam int         IDXW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int         CNTW    = $clog2(NDIG + 1);
    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] RUN_CAP = 4'(STABLE_CYCLES - 1);

    logic [SW-1:0]   sample;
    logic [SW-1:0]   s_reg;
    logic [3:0]      run;
    logic            same;
    logic            capture;
    logic [NDIG-1:0] sel_s;
    logic [7:0]      seg_s;

    logic [CNTW-1:0] low_cnt;
    logic [IDXW-1:0] low_idx;
    logic            none_active;
    logic            one_active;
    logic            multi_active;

    logic            dec_hit;
    logic            dec_blank;
    logic [3:0]      dec_hex;

    assign sample = {dig_sel, seg_in};
    assign same   = (sample == s_reg);
    assign sel_s  = s_reg[SW-1:8];
    assign seg_s  = s_reg[7:0];

    // run sits at RUN_MAX while the input stays put, so the equality compare
    // fires exactly once per stable period.
    assign capture = same && (run == RUN_CAP);

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!sel_s[i]) begin
                low_cnt = low_cnt + 1'b1;
                low_idx = IDXW'(i);
            end
        end
    end

    assign none_active  = (low_cnt == '0);
    assign one_active   = (low_cnt == CNTW'(1));
    assign multi_active = !none_active && !one_active;

    m_seg_to_hex u_seg_to_hex (
        .seg   (seg_s[6:0]),
        .hit   (dec_hit),
        .blank (dec_blank),
        .hex   (dec_hex)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg       <= {{NDIG{1'b1}}, 8'hFF};
            run         <= '0;
            digits_out  <= '0;
            dots_out    <= '0;
            valid       <= '0;
            upd         <= 1'b0;
            err_pattern <= 1'b0;
            err_sel     <= 1'b0;
        end else begin
            s_reg <= sample;

            if (!same) begin
                run <= '0;
            end else if (run != RUN_MAX) begin
                run <= run + 4'd1;
            end

            // A blanking gap between digits is not an attempt.
            upd <= capture && !none_active;

            if (capture && one_active) begin
                if (dec_hit) begin
                    digits_out[{low_idx, 2'b00} +: 4] <= dec_hex;
                    dots_out[low_idx]                 <= ~seg_s[7];
                    valid[low_idx]                    <= 1'b1;
                end else begin
                    // Blank keeps the last value/dot but marks it stale.
                    valid[low_idx] <= 1'b0;
                    if (!dec_blank) begin
                        err_pattern <= 1'b1;
                    end
                end
            end

            if (capture && multi_active) begin
                err_sel <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m_segment_scan_decoder.sv
module tb_m_segment_scan_decoder;

    localparam int NDIG = 4;
    localparam int SC   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] digits_out;
    logic [3:0]  dots_out;
    logic [3:0]  valid;
    logic        upd;
    logic        err_pattern;
    logic        err_sel;

    always #5 clk = ~clk;

    m_segment_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .digits_out  (digits_out),
        .dots_out    (dots_out),
        .valid       (valid),
        .upd         (upd),
        .err_pattern (err_pattern),
        .err_sel     (err_sel)
    );

    int checks   = 0;
    int failures = 0;
    int upd_seen = 0;

    // Independent copy of the display encoding (segments g..a, active-low).
    logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: tracks how many consecutive edges have seen the same
    // sample; a capture happens on the edge that sees it for the SC+1-th time.
    logic [3:0]  m_dig [4];
    logic [3:0]  m_dot, m_val;
    logic        m_upd, m_errp, m_errs, m_upd_known;
    logic [11:0] m_prev;
    int          m_hold;

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (enc[i] == s) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] sel, input logic [7:0] seg);
        int nlow;
        int idx;
        int v;
        m_upd_known = 1'b1;
        m_upd       = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_dot = 4'h0; m_val = 4'h0; m_errp = 1'b0; m_errs = 1'b0;
            m_prev = 12'hFFF;
            m_hold = 1;
            return;
        end
        if ({sel, seg} == m_prev) begin
            if (m_hold < 1000) m_hold++;
        end else begin
            m_prev = {sel, seg};
            m_hold = 1;
        end
        if (m_hold == SC + 1) begin
            nlow = 0;
            idx  = 0;
            for (int i = 0; i < 4; i++) if (!sel[i]) begin nlow++; idx = i; end
            if (nlow == 1) begin
                m_upd = 1'b1;
                v = dec(seg[6:0]);
                if (v >= 0) begin
                    m_dig[idx] = 4'(v);
                    m_dot[idx] = ~seg[7];
                    m_val[idx] = 1'b1;
                end else begin
                    m_val[idx] = 1'b0;
                    if (seg[6:0] != 7'h7F) m_errp = 1'b1;
                end
            end else if (nlow > 1) begin
                m_errs      = 1'b1;
                m_upd_known = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] sel, input logic [7:0] seg,
                        input string tag);
        rst     = r;
        dig_sel = sel;
        seg_in  = seg;
        @(posedge clk);
        model_edge(r, sel, seg);
        #1;
        if (upd === 1'b1) upd_seen++;
        chk({tag, "_digits"}, 32'(digits_out), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        chk({tag, "_dots"}, 32'(dots_out), 32'(m_dot));
        chk({tag, "_valid"}, 32'(valid), 32'(m_val));
        chk({tag, "_err_pattern"}, 32'(err_pattern), 32'(m_errp));
        chk({tag, "_err_sel"}, 32'(err_sel), 32'(m_errs));
        if (m_upd_known) chk({tag, "_upd"}, 32'(upd), 32'(m_upd));
    endtask

    task automatic hold(input int n, input logic [3:0] sel, input logic [7:0] seg,
                        input string tag);
        repeat (n) step(1'b0, sel, seg, tag);
    endtask

    initial begin
        logic [3:0] rsel;
        logic [7:0] rseg;
        int         k;

        rst = 1'b1; dig_sel = 4'hF; seg_in = 8'hFF;
        #2;
        step(1'b1, 4'hF, 8'hFF, "reset");
        step(1'b1, 4'hF, 8'hFF, "reset");
        chk("reset_upd", 32'(upd), 32'h0);

        // 1: digit 0 shows 0, captured at E+4
        upd_seen = 0;
        hold(6, 4'b1110, 8'b11000000, "t1");
        chk("t1_upd_cnt", 32'(upd_seen), 32'd1);
        chk("t1_valid_c", 32'(valid), 32'b0001);
        chk("t1_dig0_c", 32'(digits_out[3:0]), 32'h0);

        // 2: sweep 0-F on digit 2 with dot
        upd_seen = 0;
        for (int v = 0; v < 16; v++) hold(8, 4'b1011, {1'b0, enc[v]}, "t2");
        chk("t2_upd_cnt", 32'(upd_seen), 32'd16);
        chk("t2_dig2_c", 32'(digits_out[11:8]), 32'hF);
        chk("t2_dot2_c", 32'(dots_out[2]), 32'h1);

        // 3: glitch rejection on digit 1
        hold(8, 4'b1101, {1'b1, enc[5]}, "t3");
        upd_seen = 0;
        hold(3, 4'b1101, {1'b1, enc[8]}, "t3g");
        hold(3, 4'b1101, {1'b1, enc[5]}, "t3g");
        chk("t3_glitch_upd", 32'(upd_seen), 32'd0);
        chk("t3_dig1_keep", 32'(digits_out[7:4]), 32'h5);
        hold(6, 4'b1101, {1'b1, enc[8]}, "t3");
        chk("t3_dig1_new", 32'(digits_out[7:4]), 32'h8);

        // 4: blank then illegal on digit 1
        hold(6, 4'b1101, 8'hFF, "t4b");
        chk("t4_blank_valid", 32'(valid[1]), 32'h0);
        chk("t4_blank_err", 32'(err_pattern), 32'h0);
        hold(6, 4'b1101, 8'b11111110, "t4i");
        chk("t4_illegal_err", 32'(err_pattern), 32'h1);
        hold(6, 4'b1101, {1'b1, enc[3]}, "t4r");
        chk("t4_err_sticky", 32'(err_pattern), 32'h1);
        chk("t4_valid1", 32'(valid[1]), 32'h1);

        // 5: multi-select, then blanking gap
        hold(6, 4'b1100, {1'b1, enc[7]}, "t5m");
        chk("t5_err_sel", 32'(err_sel), 32'h1);
        chk("t5_digits_c", 32'(digits_out), 32'h0F30);
        chk("t5_valid_c", 32'(valid), 32'b0111);
        upd_seen = 0;
        hold(6, 4'b1111, 8'($urandom), "t5g");
        chk("t5_gap_upd", 32'(upd_seen), 32'd0);

        // 6: full scan, reset mid-scan, resume
        for (int d = 0; d < 4; d++) hold(8, ~(4'b0001 << d), {1'b1, enc[d+1]}, "t6");
        chk("t6_digits_c", 32'(digits_out), 32'h4321);
        hold(4, 4'b1110, {1'b1, enc[1]}, "t6");
        step(1'b1, 4'b1110, {1'b1, enc[1]}, "t6rst");
        chk("t6_rst_digits", 32'(digits_out), 32'h0);
        chk("t6_rst_valid", 32'(valid), 32'h0);
        chk("t6_rst_err", 32'({err_pattern, err_sel}), 32'h0);
        for (int d = 0; d < 4; d++) hold(8, ~(4'b0001 << d), {1'b1, enc[d+1]}, "t6r");
        chk("t6_resume_c", 32'(digits_out), 32'h4321);

        // randomized traffic against the model
        repeat (150) begin
            k = int'($urandom_range(0, 9));
            if (k < 7)       rsel = ~(4'b0001 << $urandom_range(0, 3));
            else if (k < 9)  rsel = 4'hF;
            else             rsel = 4'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    rseg = {1'($urandom_range(0, 1)), enc[$urandom_range(0, 15)]};
                2:       rseg = {1'($urandom_range(0, 1)), 7'h7F};
                default: rseg = 8'($urandom);
            endcase
            hold(int'($urandom_range(1, 8)), rsel, rseg, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
